// File: rtl/pong_state_regs.sv
// pong_state_regs
//   Game-state register bank sitting between the soft-CPU bus and the VGA
//   renderer. The CPU writes fields into shadow registers by address; a
//   commit copies the whole shadow set into the active outputs in a single
//   edge, either at the next frame_start (tear-free) or immediately.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/addr/data   : addressed register write (one per cycle)
//   commit_req        : request a shadow->active copy
//   frame_start       : start-of-vblank pulse
//   commit_mode       : 0 = wait for frame_start, 1 = immediate
//   screen_mode, icon_highlighter, speed_selector,
//   ball_xpos, ball_ypos, paddle_pos, score : active game state
//   commit_pending    : a frame-synchronous commit is armed
//   commit_done       : first cycle in which the new active values show
//   frame_count       : free-running frame_start counter (wraps)
//   overrun_count     : commit requests seen while armed (saturates)
//   wr_err            : pulse after a write to an unmapped address
module pong_state_regs #(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 11,
  parameter int SCORE_W     = 4,
  parameter int X_MAX       = 1023,
  parameter int Y_MAX       = 767,
  parameter int PAD_MAX     = 668
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [3:0]                     wr_addr,
  input  logic [31:0]                    wr_data,
  input  logic                           commit_req,
  input  logic                           frame_start,
  input  logic                           commit_mode,
  output logic [2:0]                     screen_mode,
  output logic [1:0]                     icon_highlighter,
  output logic [1:0]                     speed_selector,
  output logic [POS_W-1:0]               ball_xpos,
  output logic [POS_W-1:0]               ball_ypos,
  output logic [NUM_PLAYERS*POS_W-1:0]   paddle_pos,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic                           commit_pending,
  output logic                           commit_done,
  output logic [15:0]                    frame_count,
  output logic [7:0]                     overrun_count,
  output logic                           wr_err
);

  localparam int ADDR_PAD0   = 3;
  localparam int ADDR_SCORE0 = 3 + NUM_PLAYERS;
  localparam int ADDR_END    = 3 + 2 * NUM_PLAYERS;

  localparam logic [POS_W-1:0] X_MAX_P   = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_MAX_P   = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] PAD_MAX_P = POS_W'(PAD_MAX);
  localparam logic [31:0]      SCORE_MAX = 32'((1 << SCORE_W) - 1);

  typedef enum logic {IDLE, ARMED} state_t;

  // The comparison against the limit uses the whole 32-bit bus value, so a
  // large value with zero low bits still clamps instead of wrapping.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [31:0] d,
                                                 input logic [POS_W-1:0] mx);
    if (d > {{(32-POS_W){1'b0}}, mx}) return mx;
    else                              return d[POS_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_score(input logic [31:0] d);
    if (d > SCORE_MAX) return '1;
    else               return d[SCORE_W-1:0];
  endfunction

  state_t state_q, state_d;

  logic [6:0]         ctrl_sh_q, ctrl_sh_d, ctrl_act_q, ctrl_act_d;
  logic [POS_W-1:0]   x_sh_q, x_sh_d, x_act_q, x_act_d;
  logic [POS_W-1:0]   y_sh_q, y_sh_d, y_act_q, y_act_d;
  logic [POS_W-1:0]   pad_sh_q  [NUM_PLAYERS];
  logic [POS_W-1:0]   pad_sh_d  [NUM_PLAYERS];
  logic [POS_W-1:0]   pad_act_q [NUM_PLAYERS];
  logic [POS_W-1:0]   pad_act_d [NUM_PLAYERS];
  logic [SCORE_W-1:0] sc_sh_q   [NUM_PLAYERS];
  logic [SCORE_W-1:0] sc_sh_d   [NUM_PLAYERS];
  logic [SCORE_W-1:0] sc_act_q  [NUM_PLAYERS];
  logic [SCORE_W-1:0] sc_act_d  [NUM_PLAYERS];

  logic        commit_done_q, commit_done_d;
  logic        wr_err_q, wr_err_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  overrun_q, overrun_d;

  logic        commit_fire;
  logic        overrun_inc;
  logic [31:0] addr_ext;

  assign addr_ext = {28'd0, wr_addr};

  // Commit FSM
  always_comb begin
    state_d     = state_q;
    commit_fire = 1'b0;
    overrun_inc = 1'b0;
    case (state_q)
      IDLE: begin
        // A frame_start in the arming cycle is deliberately ignored: the
        // request waits for the next full frame boundary.
        if (commit_req) begin
          if (commit_mode) commit_fire = 1'b1;
          else             state_d     = ARMED;
        end
      end
      ARMED: begin
        if (frame_start || commit_mode) begin
          commit_fire = 1'b1;
          state_d     = IDLE;
        end
        // A request alongside a frame_start is redundant with the commit it
        // lands on, so it is tallied as an overrun and dropped. A request
        // with commit_mode=1 is the one being served and is not counted.
        if (commit_req && (!commit_fire || frame_start)) overrun_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow write decode
  always_comb begin
    ctrl_sh_d = ctrl_sh_q;
    x_sh_d    = x_sh_q;
    y_sh_d    = y_sh_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pad_sh_d[i] = pad_sh_q[i];
      sc_sh_d[i]  = sc_sh_q[i];
    end
    if (wr_en) begin
      if (addr_ext == 32'd0) ctrl_sh_d = wr_data[6:0];
      if (addr_ext == 32'd1) x_sh_d    = clamp_pos(wr_data, X_MAX_P);
      if (addr_ext == 32'd2) y_sh_d    = clamp_pos(wr_data, Y_MAX_P);
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (addr_ext == 32'(ADDR_PAD0 + i))
          pad_sh_d[i] = clamp_pos(wr_data, PAD_MAX_P);
        if (addr_ext == 32'(ADDR_SCORE0 + i))
          sc_sh_d[i] = sat_score(wr_data);
      end
    end
  end

  // Active copy: reads the pre-write shadow, so a write on the commit edge
  // lands in shadow only.
  always_comb begin
    ctrl_act_d = ctrl_act_q;
    x_act_d    = x_act_q;
    y_act_d    = y_act_q;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pad_act_d[i] = pad_act_q[i];
      sc_act_d[i]  = sc_act_q[i];
    end
    if (commit_fire) begin
      ctrl_act_d = ctrl_sh_q;
      x_act_d    = x_sh_q;
      y_act_d    = y_sh_q;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pad_act_d[i] = pad_sh_q[i];
        sc_act_d[i]  = sc_sh_q[i];
      end
    end
  end

  // Status / counters
  always_comb begin
    commit_done_d = commit_fire;
    wr_err_d      = wr_en && (addr_ext >= 32'(ADDR_END));
    frame_count_d = frame_start ? frame_count_q + 16'd1 : frame_count_q;
    overrun_d     = overrun_q;
    if (overrun_inc && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ctrl_sh_q     <= '0;
      x_sh_q        <= '0;
      y_sh_q        <= '0;
      ctrl_act_q    <= '0;
      x_act_q       <= '0;
      y_act_q       <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pad_sh_q[i]  <= '0;
        sc_sh_q[i]   <= '0;
        pad_act_q[i] <= '0;
        sc_act_q[i]  <= '0;
      end
      commit_done_q <= 1'b0;
      wr_err_q      <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_sh_q     <= ctrl_sh_d;
      x_sh_q        <= x_sh_d;
      y_sh_q        <= y_sh_d;
      ctrl_act_q    <= ctrl_act_d;
      x_act_q       <= x_act_d;
      y_act_q       <= y_act_d;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        pad_sh_q[i]  <= pad_sh_d[i];
        sc_sh_q[i]   <= sc_sh_d[i];
        pad_act_q[i] <= pad_act_d[i];
        sc_act_q[i]  <= sc_act_d[i];
      end
      commit_done_q <= commit_done_d;
      wr_err_q      <= wr_err_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign screen_mode      = ctrl_act_q[2:0];
  assign icon_highlighter = ctrl_act_q[4:3];
  assign speed_selector   = ctrl_act_q[6:5];
  assign ball_xpos        = x_act_q;
  assign ball_ypos        = y_act_q;
  assign commit_pending   = (state_q == ARMED);
  assign commit_done      = commit_done_q;
  assign frame_count      = frame_count_q;
  assign overrun_count    = overrun_q;
  assign wr_err           = wr_err_q;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pack
    assign paddle_pos[gi*POS_W +: POS_W]   = pad_act_q[gi];
    assign score[gi*SCORE_W +: SCORE_W]    = sc_act_q[gi];
  end

endmodule

// File: tb/tb_pong_state_regs.sv
// Self-checking bench for pong_state_regs (default parameters, 2 players).
// A table of stimulus rows with hand-derived expected outputs is applied one
// row per cycle; each row's expectation is queued when driven and compared
// one cycle-edge later. Long corner cases (frame counter wrap, overrun
// saturation) are hand-written sequences at the end.
module tb_pong_state_regs;

  logic        clk = 1'b0;
  logic        rst, wr_en, commit_req, frame_start, commit_mode;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  screen_mode;
  logic [1:0]  icon_highlighter, speed_selector;
  logic [10:0] ball_xpos, ball_ypos;
  logic [21:0] paddle_pos;
  logic [7:0]  score;
  logic        commit_pending, commit_done, wr_err;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  always #5 clk = ~clk;

  pong_state_regs dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .commit_req       (commit_req),
    .frame_start      (frame_start),
    .commit_mode      (commit_mode),
    .screen_mode      (screen_mode),
    .icon_highlighter (icon_highlighter),
    .speed_selector   (speed_selector),
    .ball_xpos        (ball_xpos),
    .ball_ypos        (ball_ypos),
    .paddle_pos       (paddle_pos),
    .score            (score),
    .commit_pending   (commit_pending),
    .commit_done      (commit_done),
    .frame_count      (frame_count),
    .overrun_count    (overrun_count),
    .wr_err           (wr_err)
  );

  typedef struct packed {
    logic [2:0]  sm;
    logic [1:0]  ih;
    logic [1:0]  ss;
    logic [10:0] x;
    logic [10:0] y;
    logic [21:0] pad;
    logic [7:0]  sc;
    logic        pend;
    logic        done;
    logic        err;
    logic [7:0]  ovr;
    logic [15:0] fc;
  } out_t;

  typedef struct {
    logic        r;
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
    logic        rq;
    logic        fs;
    logic        md;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  out_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic out_t snap();
    out_t s;
    s.sm   = screen_mode;
    s.ih   = icon_highlighter;
    s.ss   = speed_selector;
    s.x    = ball_xpos;
    s.y    = ball_ypos;
    s.pad  = paddle_pos;
    s.sc   = score;
    s.pend = commit_pending;
    s.done = commit_done;
    s.err  = wr_err;
    s.ovr  = overrun_count;
    s.fc   = frame_count;
    return s;
  endfunction

  // Append a row; frame_count expectation follows reset/frame_start, and the
  // one-cycle pulses are cleared for the following row.
  task automatic add(input logic r, input logic we, input logic [3:0] a,
                     input logic [31:0] d, input logic rq, input logic fs,
                     input logic md);
    vec_t v;
    if (r)       e.fc = 16'd0;
    else if (fs) e.fc = e.fc + 16'd1;
    v.r = r; v.we = we; v.a = a; v.d = d; v.rq = rq; v.fs = fs; v.md = md;
    v.exp = e;
    tbl.push_back(v);
    e.done = 1'b0;
    e.err  = 1'b0;
  endtask

  task automatic drive(input logic r, input logic we, input logic [3:0] a,
                       input logic [31:0] d, input logic rq, input logic fs,
                       input logic md);
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = a; wr_data = d;
    commit_req = rq; frame_start = fs; commit_mode = md;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    out_t got, want;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit_req = 1'b0; frame_start = 1'b0; commit_mode = 1'b0;

    // ---------------- table construction ----------------
    e = '0;
    add(1, 0, 0, 0, 0, 0, 0);                       // reset state
    add(0, 1, 1, 500, 0, 0, 0);                     // shadow x = 500
    e.x = 11'd500; e.done = 1'b1;
    add(0, 0, 0, 0, 1, 0, 1);                       // immediate commit
    add(0, 0, 0, 0, 0, 0, 0);                       // done drops
    add(0, 1, 3, 300, 0, 0, 0);                     // shadow pad0 = 300
    e.pend = 1'b1;
    add(0, 0, 0, 0, 1, 0, 0);                       // arm frame commit
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0);
    e.pad[10:0] = 11'd300; e.pend = 1'b0; e.done = 1'b1;
    add(0, 0, 0, 0, 0, 1, 0);                       // frame_start commits
    add(0, 1, 2, 2000, 0, 0, 0);                    // y clamps to 767
    add(0, 1, 5, 20, 0, 0, 0);                      // score0 saturates
    add(0, 1, 0, 32'h7F, 0, 0, 0);                  // control fields
    add(0, 1, 4, 700, 0, 0, 0);                     // pad1 clamps to 668
    add(0, 1, 6, 9, 0, 0, 0);                       // score1 = 9
    add(0, 1, 1, 32'h0001_0005, 0, 0, 0);           // upper bits -> clamp 1023
    e.sm = 3'd7; e.ih = 2'd3; e.ss = 2'd3; e.y = 11'd767; e.x = 11'd1023;
    e.pad[21:11] = 11'd668; e.sc = 8'h9F; e.done = 1'b1;
    add(0, 0, 0, 0, 1, 0, 1);
    // overrun: three consecutive requests in frame mode
    e.pend = 1'b1;
    add(0, 0, 0, 0, 1, 0, 0);
    e.ovr = 8'd1;
    add(0, 1, 3, 668, 1, 0, 0);                     // write while armed, exact max
    e.ovr = 8'd2;
    add(0, 0, 0, 0, 1, 0, 0);
    e.pend = 1'b0; e.done = 1'b1; e.pad[10:0] = 11'd668;
    add(0, 0, 0, 0, 0, 1, 0);                       // single commit
    add(0, 0, 0, 0, 0, 0, 0);
    // write in the same cycle as an immediate commit
    add(0, 1, 1, 100, 0, 0, 0);
    e.x = 11'd100; e.done = 1'b1;
    add(0, 0, 0, 0, 1, 0, 1);
    e.done = 1'b1;
    add(0, 1, 1, 200, 1, 0, 1);                     // active gets old 100
    e.x = 11'd200; e.done = 1'b1;
    add(0, 0, 0, 0, 1, 0, 1);
    // unmapped writes
    e.err = 1'b1;
    add(0, 1, 9, 5, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    e.done = 1'b1;
    add(0, 0, 0, 0, 1, 0, 1);                       // nothing changed
    e.err = 1'b1;
    add(0, 1, 7, 5, 0, 0, 0);                       // first unmapped address
    // request + frame_start in IDLE only arms
    add(0, 1, 1, 7, 0, 0, 0);
    e.pend = 1'b1;
    add(0, 0, 0, 0, 1, 1, 0);
    e.x = 11'd7; e.pend = 1'b0; e.done = 1'b1;
    add(0, 0, 0, 0, 0, 1, 0);
    // request + frame_start while armed: commit plus overrun
    e.pend = 1'b1;
    add(0, 0, 0, 0, 1, 0, 0);
    e.pend = 1'b0; e.done = 1'b1; e.ovr = 8'd3;
    add(0, 0, 0, 0, 1, 1, 0);
    // reset while armed
    add(0, 1, 1, 55, 0, 0, 0);
    e.pend = 1'b1;
    add(0, 0, 0, 0, 1, 0, 0);
    e = '0;
    add(1, 1, 1, 99, 1, 1, 1);                      // reset overrides all
    add(0, 0, 0, 0, 0, 1, 0);                       // no commit afterwards
    // armed commit forced by switching to immediate mode
    add(0, 1, 1, 9, 0, 0, 0);
    e.pend = 1'b1;
    add(0, 0, 0, 0, 1, 0, 0);
    e.pend = 1'b0; e.x = 11'd9; e.done = 1'b1;
    add(0, 0, 0, 0, 0, 0, 1);

    // ---------------- apply table ----------------
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].we, tbl[k].a, tbl[k].d,
            tbl[k].rq, tbl[k].fs, tbl[k].md);
      sb.push_back(tbl[k].exp);
      got  = snap();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL row %0d: got %h expected %h", k, got, want);
      end else begin
        $display("row %0d ok: x=%0d y=%0d pad=%h sc=%h pend=%b done=%b err=%b ovr=%0d fc=%0d",
                 k, got.x, got.y, got.pad, got.sc, got.pend, got.done,
                 got.err, got.ovr, got.fc);
      end
    end

    // ---------------- frame counter wrap ----------------
    // frame_count is 1 here; 65534 more pulses reach 0xFFFF, one more wraps.
    for (int i = 0; i < 65534; i++) drive(0, 0, 0, 0, 0, 1, 0);
    chk("frame_count_max", 32'(frame_count), 32'hFFFF);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("frame_count_wrap", 32'(frame_count), 32'h0);
    chk("wrap_no_commit", 32'(commit_done), 32'h0);
    $display("frame wrap: frame_count=%0d", frame_count);

    // ---------------- overrun saturation ----------------
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 1, 0, 0);
    chk("overrun_sat", 32'(overrun_count), 32'd255);
    chk("overrun_pend", 32'(commit_pending), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("sat_commit_done", 32'(commit_done), 32'd1);
    chk("sat_pend_clear", 32'(commit_pending), 32'd0);
    chk("sat_overrun_hold", 32'(overrun_count), 32'd255);
    $display("overrun saturation: overrun_count=%0d", overrun_count);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
